// File: rtl/gb_apu_pkg.sv
// Shared APU definitions: noise divider base table, divider width and the
// envelope direction type used by every channel with a volume envelope.
package gb_apu_pkg;

    localparam int DIV_W  = 21;
    // Shift values at or above this freeze the LFSR entirely.
    localparam int S_STOP = 14;

    // D(r): 8 for r = 0, otherwise 16*r; index with freq_dividing_ratio.
    localparam logic [7:0][7:0] DIV_BASE = {8'd112, 8'd96, 8'd80, 8'd64,
                                            8'd48,  8'd32, 8'd16, 8'd8};

    typedef enum logic {
        ENV_DEC = 1'b0,
        ENV_INC = 1'b1
    } env_dir_e;

    function automatic logic [DIV_W-1:0] div_period(input logic [2:0] r,
                                                    input logic [3:0] s);
        return DIV_W'(DIV_BASE[r]) << s;
    endfunction

endpackage

// File: rtl/gb_apu_volume_envelope.sv
// Volume envelope: loads on trigger, steps volume by one every
// num_sweeps ticks in the latched direction, saturating at both ends.
module gb_apu_volume_envelope
    import gb_apu_pkg::*;
#(
    parameter int VOL_WIDTH = 4,
    parameter int ENV_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 trigger,
    input  logic                 tick,
    input  logic [VOL_WIDTH-1:0] initial_volume,
    input  env_dir_e             dir,
    input  logic [ENV_WIDTH-1:0] num_sweeps,
    output logic [VOL_WIDTH-1:0] volume
);

    localparam logic [VOL_WIDTH-1:0] VOL_MAX = '1;

    logic [VOL_WIDTH-1:0] vol_q, vol_d;
    logic [ENV_WIDTH-1:0] timer_q, timer_d;
    logic [ENV_WIDTH-1:0] period_q, period_d;
    env_dir_e             dir_q, dir_d;

    always_comb begin
        vol_d    = vol_q;
        timer_d  = timer_q;
        period_d = period_q;
        dir_d    = dir_q;
        if (trigger) begin
            vol_d    = initial_volume;
            timer_d  = num_sweeps;
            period_d = num_sweeps;
            dir_d    = dir;
        end else if (tick && (period_q != '0)) begin
            if (timer_q <= ENV_WIDTH'(1)) begin
                timer_d = period_q;
                if (dir_q == ENV_INC) begin
                    if (vol_q != VOL_MAX) vol_d = vol_q + 1'b1;
                end else if (vol_q != '0) begin
                    vol_d = vol_q - 1'b1;
                end
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vol_q    <= '0;
            timer_q  <= '0;
            period_q <= '0;
            dir_q    <= ENV_DEC;
        end else begin
            vol_q    <= vol_d;
            timer_q  <= timer_d;
            period_q <= period_d;
            dir_q    <= dir_d;
        end
    end

    assign volume = vol_q;

endmodule

// File: rtl/gb_apu_channel_noise_param.sv
// Noise channel: LFSR clocked by a programmable divider, length counter
// and volume envelope; level is the volume gated by LFSR bit 0.
module gb_apu_channel_noise_param
    import gb_apu_pkg::*;
#(
    parameter int LFSR_WIDTH = 15,
    parameter int SHORT_TAP  = 7,
    parameter int LEN_WIDTH  = 6,
    parameter int VOL_WIDTH  = 4,
    parameter int ENV_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clk_length_ctr,
    input  logic                 clk_vol_env,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic [VOL_WIDTH-1:0] initial_volume,
    input  logic                 envelope_increasing,
    input  logic [ENV_WIDTH-1:0] num_envelope_sweeps,
    input  logic [3:0]           shift_clock_freq,
    input  logic                 counter_width,
    input  logic [2:0]           freq_dividing_ratio,
    input  logic                 start,
    input  logic                 single,
    output logic [VOL_WIDTH-1:0] level,
    output logic                 enable
);

    logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [DIV_W-1:0]      div_q, div_d;
    // One extra bit so a full 2^LEN_WIDTH count fits.
    logic [LEN_WIDTH:0]    len_q, len_d;
    logic                  enable_q, enable_d;
    logic [LEN_WIDTH-1:0]  len_load;
    logic [VOL_WIDTH-1:0]  volume;
    logic                  fb;
    logic                  lfsr_run;

    gb_apu_volume_envelope #(
        .VOL_WIDTH(VOL_WIDTH),
        .ENV_WIDTH(ENV_WIDTH)
    ) u_env (
        .clk           (clk),
        .rst_n         (reset_n),
        .trigger       (start),
        .tick          (clk_vol_env),
        .initial_volume(initial_volume),
        .dir           (env_dir_e'(envelope_increasing)),
        .num_sweeps    (num_envelope_sweeps),
        .volume        (volume)
    );

    always_comb begin
        lfsr_d   = lfsr_q;
        div_d    = div_q;
        len_d    = len_q;
        enable_d = enable_q;
        len_load = '0 - length;
        fb       = lfsr_q[0] ^ lfsr_q[1];
        lfsr_run = enable_q && (shift_clock_freq < 4'(S_STOP));
        if (start) begin
            lfsr_d   = '1;
            div_d    = div_period(freq_dividing_ratio, shift_clock_freq) - 1'b1;
            len_d    = (len_load == '0) ? {1'b1, {LEN_WIDTH{1'b0}}} : {1'b0, len_load};
            enable_d = (initial_volume != '0) || envelope_increasing;
        end else begin
            if (lfsr_run) begin
                if (div_q == '0) begin
                    lfsr_d = {fb, lfsr_q[LFSR_WIDTH-1:1]};
                    if (counter_width) lfsr_d[SHORT_TAP-1] = fb;
                    div_d = div_period(freq_dividing_ratio, shift_clock_freq) - 1'b1;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            if (clk_length_ctr && single && (len_q != '0)) begin
                len_d = len_q - 1'b1;
                if (len_q == (LEN_WIDTH+1)'(1)) enable_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_q   <= '1;
            div_q    <= '0;
            len_q    <= '0;
            enable_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            div_q    <= div_d;
            len_q    <= len_d;
            enable_q <= enable_d;
        end
    end

    assign level  = (enable_q && !lfsr_q[0]) ? volume : '0;
    assign enable = enable_q;

endmodule

// File: tb/tb_gb_apu_channel_noise_param.sv
// Bench for the noise channel: behavioural model checked every cycle plus
// directed scenarios with hand-computed expectations.
module tb_gb_apu_channel_noise_param;

    localparam int LW   = 15;
    localparam int ST   = 7;
    localparam int LNW  = 6;
    localparam int VW   = 4;
    localparam int EW   = 3;
    localparam int VMAX = (1 << VW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clk_length_ctr = 1'b0;
    logic          clk_vol_env = 1'b0;
    logic [LNW-1:0] length = '0;
    logic [VW-1:0] initial_volume = '0;
    logic          envelope_increasing = 1'b0;
    logic [EW-1:0] num_envelope_sweeps = '0;
    logic [3:0]    shift_clock_freq = '0;
    logic          counter_width = 1'b0;
    logic [2:0]    freq_dividing_ratio = '0;
    logic          start = 1'b0;
    logic          single = 1'b0;
    logic [VW-1:0] level;
    logic          enable;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    bit seq [0:299];

    gb_apu_channel_noise_param dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .clk_length_ctr     (clk_length_ctr),
        .clk_vol_env        (clk_vol_env),
        .length             (length),
        .initial_volume     (initial_volume),
        .envelope_increasing(envelope_increasing),
        .num_envelope_sweeps(num_envelope_sweeps),
        .shift_clock_freq   (shift_clock_freq),
        .counter_width      (counter_width),
        .freq_dividing_ratio(freq_dividing_ratio),
        .start              (start),
        .single             (single),
        .level              (level),
        .enable             (enable)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    function automatic int lfsr_next(input int st, input bit short_m);
        int fb;
        int nx;
        fb = (st ^ (st >> 1)) & 1;
        nx = (st >> 1) | (fb << (LW - 1));
        if (short_m) nx = (nx & ~(1 << (ST - 1))) | (fb << (ST - 1));
        return nx;
    endfunction

    function automatic int period_of(input int r, input int s);
        return ((r == 0) ? 8 : 16 * r) << s;
    endfunction

    function automatic int periodic(input int p, input bit sm);
        int a;
        int b;
        a = (1 << LW) - 1;
        b = a;
        for (int i = 0; i < p; i++) b = lfsr_next(b, sm);
        for (int i = 0; i < 200; i++) begin
            if ((a & 1) != (b & 1)) return 0;
            a = lfsr_next(a, sm);
            b = lfsr_next(b, sm);
        end
        return 1;
    endfunction

    function automatic int first_zero(input bit sm);
        int a;
        int n;
        a = (1 << LW) - 1;
        n = 0;
        while ((a & 1) && n < 100) begin
            a = lfsr_next(a, sm);
            n++;
        end
        return n;
    endfunction

    int m_lfsr, m_vol, m_len, m_env_left, m_env_per, m_elapsed, m_period;
    bit m_en, m_env_up;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_en <= 1'b0; m_lfsr <= (1 << LW) - 1; m_vol <= 0; m_len <= 0;
            m_env_left <= 0; m_env_per <= 0; m_env_up <= 1'b0;
            m_elapsed <= 0; m_period <= 0;
        end else if (start) begin
            m_lfsr     <= (1 << LW) - 1;
            m_vol      <= int'(initial_volume);
            m_env_per  <= int'(num_envelope_sweeps);
            m_env_left <= int'(num_envelope_sweeps);
            m_env_up   <= envelope_increasing;
            m_elapsed  <= 0;
            m_period   <= period_of(int'(freq_dividing_ratio), int'(shift_clock_freq));
            m_len      <= (1 << LNW) - int'(length);
            m_en       <= (initial_volume != '0) || envelope_increasing;
        end else begin
            if (m_en && int'(shift_clock_freq) < 14) begin
                if (m_elapsed + 1 == m_period) begin
                    m_lfsr    <= lfsr_next(m_lfsr, counter_width);
                    m_elapsed <= 0;
                    m_period  <= period_of(int'(freq_dividing_ratio), int'(shift_clock_freq));
                end else begin
                    m_elapsed <= m_elapsed + 1;
                end
            end
            if (clk_length_ctr && single && m_len > 0) begin
                m_len <= m_len - 1;
                if (m_len == 1) m_en <= 1'b0;
            end
            if (clk_vol_env && m_env_per != 0) begin
                if (m_env_left <= 1) begin
                    m_env_left <= m_env_per;
                    if (m_env_up) m_vol <= (m_vol < VMAX) ? m_vol + 1 : m_vol;
                    else          m_vol <= (m_vol > 0) ? m_vol - 1 : 0;
                end else begin
                    m_env_left <= m_env_left - 1;
                end
            end
        end
    end

    function automatic int exp_level();
        return (m_en && (m_lfsr & 1) == 0) ? m_vol : 0;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int got, input int want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0d want=%0d", nm, $time, got, want);
        end
    endtask

    task automatic do_start(input bit ltk, input bit etk);
        start = 1'b1; clk_length_ctr = ltk; clk_vol_env = etk;
        @(negedge clk);
        start = 1'b0; clk_length_ctr = 1'b0; clk_vol_env = 1'b0;
    endtask

    task automatic len_tick();
        clk_length_ctr = 1'b1;
        @(negedge clk);
        clk_length_ctr = 1'b0;
    endtask

    task automatic env_tick();
        clk_vol_env = 1'b1;
        @(negedge clk);
        clk_vol_env = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Trigger, let 15 LFSR steps bring bit 0 low, then freeze the LFSR so
    // level shows the envelope volume directly.
    task automatic arm(input bit etk);
        shift_clock_freq = 4'd0; freq_dividing_ratio = 3'd0; counter_width = 1'b0;
        do_start(1'b0, etk);
        wait_cyc(120);
        shift_clock_freq = 4'd14;
    endtask

    initial begin
        int mism;
        int ones;

        // Reset state
        wait_cyc(3);
        chk("rst_level", int'(level), 0);
        chk("rst_enable", int'(enable), 0);
        reset_n = 1'b1;
        chk_on  = 1'b1;
        fork
            forever begin
                @(negedge clk);
                if (chk_on) begin
                    chk("cycle_level", int'(level), exp_level());
                    chk("cycle_enable", int'(enable), int'(m_en));
                end
            end
        join_none

        // Model pins
        chk("mdl_period_r0s0", period_of(0, 0), 8);
        chk("mdl_period_r3s2", period_of(3, 2), 192);
        chk("mdl_short_127", periodic(127, 1'b1), 1);
        chk("mdl_short_not1", periodic(1, 1'b1), 0);
        chk("mdl_long_32767", periodic(32767, 1'b0), 1);
        chk("mdl_long_not4681", periodic(4681, 1'b0), 0);
        chk("mdl_long_not1057", periodic(1057, 1'b0), 0);
        chk("mdl_long_not217", periodic(217, 1'b0), 0);
        chk("mdl_first_zero_long", first_zero(1'b0), 15);
        chk("mdl_first_zero_short", first_zero(1'b1), 7);

        // LFSR timing: level first goes to 1 after 15 steps of 8 cycles
        @(negedge clk);
        initial_volume = 4'd1; envelope_increasing = 1'b0; num_envelope_sweeps = 3'd0;
        freq_dividing_ratio = 3'd0; shift_clock_freq = 4'd0; counter_width = 1'b0; single = 1'b0;
        do_start(1'b0, 1'b0);
        chk("lfsr_en", int'(enable), 1);
        wait_cyc(119);
        chk("lfsr_pre120", int'(level), 0);
        chk("mdl_pre120", exp_level(), 0);
        wait_cyc(1);
        chk("lfsr_at120", int'(level), 1);
        chk("mdl_at120", exp_level(), 1);

        // Length counter: 64 - 40 = 24 ticks
        initial_volume = 4'd15; single = 1'b1; length = 6'd40;
        do_start(1'b0, 1'b0);
        repeat (23) len_tick();
        chk("len_23", int'(enable), 1);
        len_tick();
        chk("len_24", int'(enable), 0);
        single = 1'b0;
        do_start(1'b0, 1'b0);
        repeat (100) len_tick();
        chk("len_single0", int'(enable), 1);

        // Start coincident with length tick: count 64 - 60 = 4, not 3
        single = 1'b1; length = 6'd60;
        do_start(1'b1, 1'b0);
        repeat (3) len_tick();
        chk("col_len3", int'(enable), 1);
        len_tick();
        chk("col_len4", int'(enable), 0);
        single = 1'b0;

        // Envelope up, period 1, with a start/env-tick collision
        initial_volume = 4'd1; envelope_increasing = 1'b1; num_envelope_sweeps = 3'd1;
        arm(1'b1);
        chk("env_col", int'(level), 1);
        for (int k = 1; k <= 20; k++) begin
            env_tick();
            chk("env_up1", int'(level), (k + 1 > 15) ? 15 : k + 1);
        end
        // Period 3
        num_envelope_sweeps = 3'd3;
        arm(1'b0);
        for (int k = 1; k <= 9; k++) begin
            env_tick();
            chk("env_up3", int'(level), 1 + k / 3);
        end
        // Down with saturation at 0
        initial_volume = 4'd2; envelope_increasing = 1'b0; num_envelope_sweeps = 3'd1;
        arm(1'b0);
        chk("env_dn0", int'(level), 2);
        env_tick(); chk("env_dn1", int'(level), 1);
        env_tick(); chk("env_dn2", int'(level), 0);
        env_tick(); chk("env_dn3", int'(level), 0);
        chk("env_dn_en", int'(enable), 1);
        // Frozen
        initial_volume = 4'd9; envelope_increasing = 1'b1; num_envelope_sweeps = 3'd0;
        arm(1'b0);
        repeat (5) env_tick();
        chk("env_frozen", int'(level), 9);

        // DAC off
        initial_volume = 4'd0; envelope_increasing = 1'b0; num_envelope_sweeps = 3'd1;
        shift_clock_freq = 4'd0;
        do_start(1'b0, 1'b0);
        wait_cyc(50);
        chk("dac_off_en", int'(enable), 0);
        chk("dac_off_level", int'(level), 0);

        // Short mode: bit 0 sequence repeats every 127 steps, 64 ones per period
        initial_volume = 4'd15; num_envelope_sweeps = 3'd0; counter_width = 1'b1;
        freq_dividing_ratio = 3'd0; shift_clock_freq = 4'd0;
        do_start(1'b0, 1'b0);
        for (int i = 0; i < 254; i++) begin
            wait_cyc(8);
            seq[i] = (level == '0);
        end
        mism = 0; ones = 0;
        for (int i = 0; i < 127; i++) begin
            if (seq[i] != seq[i + 127]) mism++;
            if (seq[i]) ones++;
        end
        chk("short_period", mism, 0);
        chk("short_ones", ones, 64);

        // Long mode: not periodic at 127; model (pinned to 32767) checks each cycle
        counter_width = 1'b0;
        do_start(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            wait_cyc(8);
            seq[i] = (level == '0);
        end
        mism = 0;
        for (int i = 0; i < 127; i++) if (seq[i] != seq[i + 127]) mism++;
        chk("long_not127", int'(mism > 0), 1);
        wait_cyc(3);
        counter_width = 1'b1;
        wait_cyc(800);
        counter_width = 1'b0; freq_dividing_ratio = 3'd1;
        wait_cyc(800);
        freq_dividing_ratio = 3'd2; shift_clock_freq = 4'd1;
        wait_cyc(1500);

        // Asynchronous reset mid-run
        initial_volume = 4'd5; envelope_increasing = 1'b0; num_envelope_sweeps = 3'd0;
        arm(1'b0);
        chk("pre_rst_level", int'(level), 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_async_level", int'(level), 0);
        chk("rst_async_en", int'(enable), 0);
        @(negedge clk);
        reset_n = 1'b1;
        shift_clock_freq = 4'd0;
        wait_cyc(30);
        chk("post_rst_en", int'(enable), 0);
        chk("post_rst_level", int'(level), 0);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
